draw_frame_sched: RTL

Frame-synchronous scheduler for the background/board draw stage's configuration word (fill colour/theme).
- Arbitrates update requests from several sources (game FSM, menu, timer).
- Holds at most one accepted update pending.
- Commits the pending update only at the start of vertical blanking, so the draw stage never changes colour mid-frame.
- Sits between the control logic and the draw pipeline; its cfg output drives the draw stage's fill colour.

---
 rtl/draw_sched_pkg.sv | 23 ++
 rtl/rr_arbiter.sv | 61 ++++++
 rtl/draw_frame_sched.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/draw_sched_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : draw_sched_pkg                                              |
// | Brief    : Shared types and default sizes for the frame-synchronous    |
// |            draw configuration scheduler.                               |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
package draw_sched_pkg;

   // Scheduler phases: wait for a request, hold it until vblank, publish it.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      COMMIT  = 2'd2
   } sched_state_t;

   localparam int                   N_REQ_DEF   = 3;
   localparam int                   CFG_W_DEF   = 12;
   localparam logic [CFG_W_DEF-1:0] CFG_RST_DEF = 12'h888;
   localparam int                   CNT_W_DEF   = 16;

endpackage : draw_sched_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : rr_arbiter                                                  |
// | Brief    : Combinational arbiter returning a one-hot grant and the     |
// |            winner index. Round-robin from ptr by default; lowest index |
// |            wins when DRAW_SCHED_FIXED_PRIO_EN is defined.              |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module rr_arbiter #(
   parameter int N     = 3,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   input  logic             enable,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] winner
);

`ifdef DRAW_SCHED_FIXED_PRIO_EN
   // The pointer has no meaning under fixed priority.
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   // Lowest-index requester wins; the descending scan lets the lowest one overwrite.
   always_comb begin
      grant  = '0;
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (enable && req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            winner   = IDX_W'(i);
         end
      end
   end
`else
   // Round-robin: lowest requester at or above ptr, else lowest requester below ptr.
   // The second scan runs last so the at-or-above region overrides the wrap region.
   always_comb begin
      grant  = '0;
      winner = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (enable && req[i] && (IDX_W'(i) < ptr)) begin
            grant    = '0;
            grant[i] = 1'b1;
            winner   = IDX_W'(i);
         end
      end
      for (int i = N - 1; i >= 0; i--) begin
         if (enable && req[i] && (IDX_W'(i) >= ptr)) begin
            grant    = '0;
            grant[i] = 1'b1;
            winner   = IDX_W'(i);
         end
      end
   end
`endif

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/draw_frame_sched.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : draw_frame_sched                                            |
// | Brief    : Accepts one draw-configuration update at a time from        |
// |            N_REQ requesters and applies it only at the start of        |
// |            vertical blanking, so the fill colour never changes         |
// |            mid-frame. Also counts frames (vblnk rising edges).         |
// |            Build option DRAW_SCHED_FIXED_PRIO_EN selects fixed         |
// |            lowest-index priority instead of round-robin.               |
// | Revision : 1.0 - initial release                                       |
// +-----------------------------------------------------------------------+
module draw_frame_sched
   import draw_sched_pkg::*;
#(
   parameter int               N_REQ   = N_REQ_DEF,
   parameter int               CFG_W   = CFG_W_DEF,
   parameter logic [CFG_W-1:0] CFG_RST = CFG_W'(CFG_RST_DEF),
   parameter int               CNT_W   = CNT_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vblnk,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*CFG_W-1:0] req_cfg,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       done,
   output logic [CFG_W-1:0]       cfg,
   output logic                   cfg_upd,
   output logic [CNT_W-1:0]       frame_cnt
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   sched_state_t     state_q,     state_d;
   logic             vblnk_dly_q;
   logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic [CFG_W-1:0] cfg_q,       cfg_d;
   logic             cfg_upd_q,   cfg_upd_d;
   logic [N_REQ-1:0] gnt_q,       gnt_d;
   logic [N_REQ-1:0] done_q,      done_d;
   logic [CFG_W-1:0] pend_cfg_q,  pend_cfg_d;
   logic [IDX_W-1:0] pend_id_q,   pend_id_d;

   logic             vs_rise;
   logic [N_REQ-1:0] arb_grant;
   logic [IDX_W-1:0] arb_win;
   logic [IDX_W-1:0] arb_ptr;
   logic [CFG_W-1:0] sel_cfg;

   assign vs_rise = vblnk & ~vblnk_dly_q;

   rr_arbiter #(
      .N     (N_REQ),
      .IDX_W (IDX_W)
   ) u_arb (
      .req    (req),
      .ptr    (arb_ptr),
      .enable (state_q == IDLE),
      .grant  (arb_grant),
      .winner (arb_win)
   );

`ifdef DRAW_SCHED_FIXED_PRIO_EN
   assign arb_ptr = '0;
`else
   logic [IDX_W-1:0] ptr_q, ptr_d;

   assign arb_ptr = ptr_q;

   // Advance the round-robin pointer just past each winner.
   always_comb begin
      ptr_d = ptr_q;
      if (|arb_grant) begin
         ptr_d = (arb_win == IDX_W'(N_REQ - 1)) ? '0 : arb_win + 1'b1;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end
`endif

   // Pick the winner's config slice; req_cfg is only looked at in the grant cycle.
   always_comb begin
      sel_cfg = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_cfg = req_cfg[i*CFG_W +: CFG_W];
         end
      end
   end

   // Next-state, pending-slot and output pulse logic of the scheduler.
   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      cfg_d       = cfg_q;
      cfg_upd_d   = 1'b0;
      gnt_d       = '0;
      done_d      = '0;
      pend_cfg_d  = pend_cfg_q;
      pend_id_d   = pend_id_q;

      // Frame counting runs independently of the update flow.
      if (vs_rise) begin
         frame_cnt_d = frame_cnt_q + 1'b1;
      end

      case (state_q)
         IDLE: begin
            // A vs_rise in this cycle is ignored: the new update waits a full frame.
            if (|arb_grant) begin
               gnt_d      = arb_grant;
               pend_cfg_d = sel_cfg;
               pend_id_d  = arb_win;
               state_d    = PENDING;
            end
         end
         PENDING: begin
            if (vs_rise) begin
               cfg_d     = pend_cfg_q;
               cfg_upd_d = 1'b1;
               for (int i = 0; i < N_REQ; i++) begin
                  done_d[i] = (pend_id_q == IDX_W'(i));
               end
               state_d = COMMIT;
            end
         end
         COMMIT: begin
            // Output pulses are visible this cycle; no grant until back in IDLE.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Single register stage for state, pending slot and all outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         vblnk_dly_q <= 1'b0;
         frame_cnt_q <= '0;
         cfg_q       <= CFG_RST;
         cfg_upd_q   <= 1'b0;
         gnt_q       <= '0;
         done_q      <= '0;
         pend_cfg_q  <= '0;
         pend_id_q   <= '0;
      end else begin
         state_q     <= state_d;
         vblnk_dly_q <= vblnk;
         frame_cnt_q <= frame_cnt_d;
         cfg_q       <= cfg_d;
         cfg_upd_q   <= cfg_upd_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         pend_cfg_q  <= pend_cfg_d;
         pend_id_q   <= pend_id_d;
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign cfg       = cfg_q;
   assign cfg_upd   = cfg_upd_q;
   assign frame_cnt = frame_cnt_q;

endmodule : draw_frame_sched
`default_nettype wire
